// File: rtl/game_obj_pkg.sv
// Shared encodings, screen geometry and sprite attributes for the game object drawers.
package game_obj_pkg;

  localparam int unsigned SCR_W    = 160;
  localparam int unsigned SCR_H    = 120;
  localparam int unsigned X_W      = 8;
  localparam int unsigned Y_W      = 7;
  localparam int unsigned COL_W    = 3;
  localparam int unsigned CNT_W    = 3;
  localparam int unsigned IDX_W    = 3;
  localparam int unsigned KIND_W   = 2;
  localparam int unsigned SZ_W     = 4;
  localparam int unsigned D_W      = 3;

  localparam int unsigned GOLD_SZ  = 8;
  localparam int unsigned STONE_SZ = 6;
  localparam int unsigned DIAM_SZ  = 4;

  localparam logic [COL_W-1:0] GOLD_COL  = 3'b110;
  localparam logic [COL_W-1:0] STONE_COL = 3'b111;
  localparam logic [COL_W-1:0] DIAM_COL  = 3'b011;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [KIND_W-1:0] {
    KIND_GOLD  = 2'd0,
    KIND_STONE = 2'd1,
    KIND_DIAM  = 2'd2
  } obj_kind_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_PLOT    = 3'd2,
    ST_DONE    = 3'd3,
    ST_RELEASE = 3'd4
  } draw_state_e;

  // Top-left corner and presence of one object, as read from the position table.
  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic           valid;
  } obj_pos_t;

  function automatic logic [SZ_W-1:0] kind_size(input obj_kind_e k);
    case (k)
      KIND_GOLD:  return SZ_W'(GOLD_SZ);
      KIND_STONE: return SZ_W'(STONE_SZ);
      default:    return SZ_W'(DIAM_SZ);
    endcase
  endfunction

  function automatic logic [COL_W-1:0] kind_colour(input obj_kind_e k);
    case (k)
      KIND_GOLD:  return GOLD_COL;
      KIND_STONE: return STONE_COL;
      default:    return DIAM_COL;
    endcase
  endfunction

endpackage

// File: rtl/obj_pixel_scan.sv
// Raster offset counter for a square sprite: dx runs fastest, both wrap at size-1.
module obj_pixel_scan
  import game_obj_pkg::*;
(
  input  logic            clk,
  input  logic            resetn,
  input  logic            clear,
  input  logic            step,
  input  logic [SZ_W-1:0] size,
  output logic [D_W-1:0]  dx,
  output logic [D_W-1:0]  dy,
  output logic            last
);

  logic dx_end;
  logic dy_end;

  assign dx_end = (SZ_W'(dx) == size - SZ_W'(1));
  assign dy_end = (SZ_W'(dy) == size - SZ_W'(1));
  assign last   = dx_end && dy_end;

  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      dx <= '0;
      dy <= '0;
    end else if (step) begin
      if (dx_end) begin
        dx <= '0;
        dy <= dy_end ? '0 : dy + D_W'(1);
      end else begin
        dx <= dx + D_W'(1);
      end
    end
  end

endmodule

// File: rtl/object_sprite_drawer.sv
// Scans one solid square sprite per request into the VGA adapter and advances
// the per-kind object counters used by the view FSM to sequence objects.
module object_sprite_drawer
  import game_obj_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              enable_draw_gold,
  input  logic              enable_draw_stone,
  input  logic              enable_draw_diamond,
  input  logic              resetn_gold_stone_diamond,
  input  logic [X_W-1:0]    pos_x,
  input  logic [Y_W-1:0]    pos_y,
  input  logic              pos_valid,
  output logic [KIND_W-1:0] pos_kind,
  output logic [IDX_W-1:0]  pos_index,
  output logic [X_W-1:0]    x,
  output logic [Y_W-1:0]    y,
  output logic [COL_W-1:0]  colour,
  output logic              plot,
  output logic              draw_gold_done,
  output logic              draw_stone_done,
  output logic              draw_diamond_done,
  output logic [CNT_W-1:0]  gold_count,
  output logic [CNT_W-1:0]  stone_count,
  output logic [CNT_W-1:0]  diamond_count
);

  draw_state_e      state_q, state_d;
  obj_kind_e        kind_q, kind_sel;
  obj_pos_t         base_q;
  logic [D_W-1:0]   dx, dy;
  logic             last;
  logic             scan_clear, scan_step;
  logic             any_en, kind_en;
  logic [CNT_W-1:0] sel_count;
  logic [X_W:0]     sum_x;
  logic [Y_W:0]     sum_y;
  logic             in_bounds;

  assign any_en = enable_draw_gold || enable_draw_stone || enable_draw_diamond;

  // Request arbitration: gold over stone over diamond.
  always_comb begin
    if (enable_draw_gold) begin
      kind_sel  = KIND_GOLD;
      sel_count = gold_count;
    end else if (enable_draw_stone) begin
      kind_sel  = KIND_STONE;
      sel_count = stone_count;
    end else begin
      kind_sel  = KIND_DIAM;
      sel_count = diamond_count;
    end
  end

  always_comb begin
    case (kind_q)
      KIND_GOLD:  kind_en = enable_draw_gold;
      KIND_STONE: kind_en = enable_draw_stone;
      default:    kind_en = enable_draw_diamond;
    endcase
  end

  // 9/8-bit sums so that sprites hanging off the right/bottom edge clip instead of wrapping.
  assign sum_x     = (X_W+1)'(base_q.x) + (X_W+1)'(dx);
  assign sum_y     = (Y_W+1)'(base_q.y) + (Y_W+1)'(dy);
  assign in_bounds = base_q.valid && (sum_x < (X_W+1)'(SCR_W)) && (sum_y < (Y_W+1)'(SCR_H));

  obj_pixel_scan u_scan (
    .clk    (clk),
    .resetn (resetn),
    .clear  (scan_clear),
    .step   (scan_step),
    .size   (kind_size(kind_q)),
    .dx     (dx),
    .dy     (dy),
    .last   (last)
  );

  always_ff @(posedge clk) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next state; dropping the latched enable during LOAD/PLOT abandons the object.
  always_comb begin
    state_d    = state_q;
    scan_clear = 1'b0;
    scan_step  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_en) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (!kind_en) begin
          state_d = ST_IDLE;
        end else if (!pos_valid) begin
          state_d = ST_DONE;
        end else begin
          scan_clear = 1'b1;
          state_d    = ST_PLOT;
        end
      end
      ST_PLOT: begin
        if (!kind_en) begin
          state_d = ST_IDLE;
        end else begin
          scan_step = 1'b1;
          if (last) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!any_en) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Registered VGA, table-address and completion outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      kind_q            <= KIND_GOLD;
      base_q            <= '0;
      pos_kind          <= '0;
      pos_index         <= '0;
      x                 <= '0;
      y                 <= '0;
      colour            <= '0;
      plot              <= 1'b0;
      draw_gold_done    <= 1'b0;
      draw_stone_done   <= 1'b0;
      draw_diamond_done <= 1'b0;
    end else begin
      plot              <= 1'b0;
      draw_gold_done    <= 1'b0;
      draw_stone_done   <= 1'b0;
      draw_diamond_done <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (any_en) begin
            kind_q    <= kind_sel;
            pos_kind  <= kind_sel;
            pos_index <= IDX_W'(sel_count);
          end
        end
        ST_LOAD: begin
          base_q <= '{x: pos_x, y: pos_y, valid: pos_valid};
        end
        ST_PLOT: begin
          if (kind_en) begin
            x      <= sum_x[X_W-1:0];
            y      <= sum_y[Y_W-1:0];
            colour <= kind_colour(kind_q);
            plot   <= in_bounds;
          end
        end
        ST_DONE: begin
          draw_gold_done    <= (kind_q == KIND_GOLD);
          draw_stone_done   <= (kind_q == KIND_STONE);
          draw_diamond_done <= (kind_q == KIND_DIAM);
        end
        default: begin
        end
      endcase
    end
  end

  // Counters advance as the done pulse is seen; the external clear takes priority.
  always_ff @(posedge clk) begin
    if (!resetn || !resetn_gold_stone_diamond) begin
      gold_count    <= '0;
      stone_count   <= '0;
      diamond_count <= '0;
    end else begin
      if (draw_gold_done && gold_count != CNT_MAX)
        gold_count <= gold_count + CNT_W'(1);
      if (draw_stone_done && stone_count != CNT_MAX)
        stone_count <= stone_count + CNT_W'(1);
      if (draw_diamond_done && diamond_count != CNT_MAX)
        diamond_count <= diamond_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_object_sprite_drawer.sv
// Table-driven bench for object_sprite_drawer with a pixel scoreboard and hand-written corner sequences.
module tb_object_sprite_drawer;

  logic       clk = 1'b0;
  logic       resetn;
  logic       enable_draw_gold, enable_draw_stone, enable_draw_diamond;
  logic       resetn_gold_stone_diamond;
  logic [7:0] pos_x;
  logic [6:0] pos_y;
  logic       pos_valid;
  logic [1:0] pos_kind;
  logic [2:0] pos_index;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       draw_gold_done, draw_stone_done, draw_diamond_done;
  logic [2:0] gold_count, stone_count, diamond_count;

  always #5 clk = ~clk;

  object_sprite_drawer dut (
    .clk                       (clk),
    .resetn                    (resetn),
    .enable_draw_gold          (enable_draw_gold),
    .enable_draw_stone         (enable_draw_stone),
    .enable_draw_diamond       (enable_draw_diamond),
    .resetn_gold_stone_diamond (resetn_gold_stone_diamond),
    .pos_x                     (pos_x),
    .pos_y                     (pos_y),
    .pos_valid                 (pos_valid),
    .pos_kind                  (pos_kind),
    .pos_index                 (pos_index),
    .x                         (x),
    .y                         (y),
    .colour                    (colour),
    .plot                      (plot),
    .draw_gold_done            (draw_gold_done),
    .draw_stone_done           (draw_stone_done),
    .draw_diamond_done         (draw_diamond_done),
    .gold_count                (gold_count),
    .stone_count               (stone_count),
    .diamond_count             (diamond_count)
  );

  // Object position table addressed by the DUT.
  logic [7:0] tbl_x [4][8];
  logic [6:0] tbl_y [4][8];
  logic       tbl_v [4][8];
  assign pos_x     = tbl_x[pos_kind][pos_index];
  assign pos_y     = tbl_y[pos_kind][pos_index];
  assign pos_valid = tbl_v[pos_kind][pos_index];

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  typedef struct {
    logic [2:0] en;      // {diamond, stone, gold}
    logic [7:0] px;
    logic [6:0] py;
    logic       pv;
    int         exp_kind;
    int         exp_plots;
    int         exp_count;
    int         hold;
  } vec_t;

  pix_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   plot_seen = 0;
  int   done_total = 0;
  int   model_cnt [3];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int sz_of(input int k);
    return (k == 0) ? 8 : (k == 1) ? 6 : 4;
  endfunction

  function automatic logic [2:0] col_of(input int k);
    return (k == 0) ? 3'b110 : (k == 1) ? 3'b111 : 3'b011;
  endfunction

  task automatic push_pixels(input int k, input int px, input int py);
    pix_t p;
    for (int dy = 0; dy < sz_of(k); dy++)
      for (int dx = 0; dx < sz_of(k); dx++)
        if (px + dx < 160 && py + dy < 120) begin
          p.x = 8'(px + dx);
          p.y = 7'(py + dy);
          p.c = col_of(k);
          exp_q.push_back(p);
        end
  endtask

  // Scoreboard consumer: every plot strobe must match the next expected pixel.
  always @(negedge clk) begin
    if (resetn) begin
      if (plot) begin
        plot_seen++;
        if (exp_q.size() == 0) chk("unexpected_plot", 1, 0);
        else chk("pixel_xyc", int'({x, y, colour}), int'(exp_q.pop_front()));
      end
      if (draw_gold_done || draw_stone_done || draw_diamond_done) done_total++;
    end
  end

  function automatic int counts_now();
    return int'({gold_count, stone_count, diamond_count});
  endfunction

  function automatic int counts_model();
    return (model_cnt[0] << 6) | (model_cnt[1] << 3) | model_cnt[2];
  endfunction

  // clr_mode: 0 none, 1 clear in the done cycle, 2 clear mid-scan.
  task automatic run_draw(input vec_t v, input int clr_mode, input string tag);
    int k, idx, c, first_plot, ps, dt, lat, kc;
    bit seen;
    k   = v.exp_kind;
    idx = model_cnt[k];
    tbl_x[k][idx] = v.px;
    tbl_y[k][idx] = v.py;
    tbl_v[k][idx] = v.pv;
    if (v.pv) push_pixels(k, int'(v.px), int'(v.py));
    ps = plot_seen;
    @(posedge clk); #1;
    {enable_draw_diamond, enable_draw_stone, enable_draw_gold} = v.en;
    c = 0; seen = 1'b0; first_plot = -1;
    while (!seen && c < 200) begin
      @(negedge clk);
      if (plot && first_plot < 0) first_plot = c;
      if (clr_mode == 2 && c == 8) resetn_gold_stone_diamond = 1'b0;
      if (clr_mode == 2 && c == 9) resetn_gold_stone_diamond = 1'b1;
      if (draw_gold_done || draw_stone_done || draw_diamond_done) seen = 1'b1;
      else c++;
    end
    chk({tag, "_done_seen"}, int'(seen), 1);
    lat = v.pv ? 3 + sz_of(k) * sz_of(k) : 3;
    chk({tag, "_done_latency"}, c, lat);
    chk({tag, "_done_kind"}, int'({draw_diamond_done, draw_stone_done, draw_gold_done}), 1 << k);
    if (v.exp_plots > 0) chk({tag, "_first_pixel_cycle"}, first_plot, 3);
    if (clr_mode == 1) resetn_gold_stone_diamond = 1'b0;
    @(negedge clk);
    resetn_gold_stone_diamond = 1'b1;
    chk({tag, "_done_one_cycle"}, int'({draw_diamond_done, draw_stone_done, draw_gold_done}), 0);
    chk({tag, "_plot_count"}, plot_seen - ps, v.exp_plots);
    chk({tag, "_queue_drained"}, exp_q.size(), 0);
    if (clr_mode == 1) begin
      model_cnt = '{0, 0, 0};
    end else begin
      if (clr_mode == 2) model_cnt = '{0, 0, 0};
      model_cnt[k] = (idx + 1 > 7) ? 7 : idx + 1;
      if (clr_mode == 2) model_cnt[k] = 1;
    end
    @(negedge clk);
    kc = (k == 0) ? int'(gold_count) : (k == 1) ? int'(stone_count) : int'(diamond_count);
    chk({tag, "_count"}, kc, v.exp_count);
    chk({tag, "_all_counts"}, counts_now(), counts_model());
    if (v.hold > 0) begin
      dt = done_total; ps = plot_seen;
      repeat (v.hold) @(negedge clk);
      chk({tag, "_hold_no_redraw"}, (done_total - dt) + (plot_seen - ps), 0);
    end
    {enable_draw_diamond, enable_draw_stone, enable_draw_gold} = 3'b000;
    repeat (3) @(negedge clk);
  endtask

  vec_t vecs [8];
  vec_t hv;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ps, dt, c;
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 8; i++) begin
        tbl_x[k][i] = '0; tbl_y[k][i] = '0; tbl_v[k][i] = 1'b0;
      end
    model_cnt = '{0, 0, 0};
    //           en      px   py   pv  kind plots cnt hold
    vecs[0] = '{3'b001, 8'd10,  7'd20,  1'b1, 0, 64, 1, 0};
    vecs[1] = '{3'b010, 8'd50,  7'd60,  1'b0, 1, 0,  1, 0};
    vecs[2] = '{3'b100, 8'd158, 7'd118, 1'b1, 2, 4,  1, 0};
    vecs[3] = '{3'b111, 8'd30,  7'd40,  1'b1, 0, 64, 2, 20};
    vecs[4] = '{3'b010, 8'd154, 7'd100, 1'b1, 1, 36, 2, 0};
    vecs[5] = '{3'b100, 8'd0,   7'd0,   1'b1, 2, 16, 2, 0};
    vecs[6] = '{3'b001, 8'd156, 7'd116, 1'b1, 0, 16, 3, 0};
    vecs[7] = '{3'b110, 8'd5,   7'd5,   1'b1, 1, 36, 3, 0};

    resetn = 1'b0;
    resetn_gold_stone_diamond = 1'b1;
    {enable_draw_diamond, enable_draw_stone, enable_draw_gold} = 3'b000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", int'({x, y, colour, plot, draw_gold_done, draw_stone_done,
                               draw_diamond_done, pos_kind, pos_index}), 0);
    chk("reset_counts", counts_now(), 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) run_draw(vecs[i], 0, "vec");

    // Abort: drop gold once pixel 30 has been plotted.
    tbl_x[0][model_cnt[0]] = 8'd40;
    tbl_y[0][model_cnt[0]] = 7'd50;
    tbl_v[0][model_cnt[0]] = 1'b1;
    push_pixels(0, 40, 50);
    ps = plot_seen; dt = done_total;
    @(posedge clk); #1;
    enable_draw_gold = 1'b1;
    c = 0;
    while (plot_seen - ps < 31 && c < 100) begin
      @(negedge clk); #1;
      c++;
    end
    chk("abort_reached_px30", plot_seen - ps, 31);
    enable_draw_gold = 1'b0;
    @(negedge clk);
    chk("abort_plot_low", int'(plot), 0);
    repeat (10) @(negedge clk);
    chk("abort_no_done", done_total - dt, 0);
    chk("abort_no_more_plots", plot_seen - ps, 31);
    chk("abort_counts", counts_now(), counts_model());
    exp_q.delete();

    // Clear coinciding with the gold done pulse (gold_count 3) wins.
    hv = '{3'b001, 8'd70, 7'd70, 1'b1, 0, 64, 0, 0};
    run_draw(hv, 1, "clr_on_done");

    // Gold counter saturates at 7.
    for (int i = 0; i < 8; i++) begin
      hv = '{3'b001, 8'(20 + 2 * i), 7'd30, 1'b1, 0, 64, (i < 7) ? i + 1 : 7, 0};
      run_draw(hv, 0, "sat");
    end

    // Clear during a stone scan zeroes counts without disturbing the scan.
    hv = '{3'b010, 8'd90, 7'd10, 1'b1, 1, 36, 1, 0};
    run_draw(hv, 0, "stone_pre");
    hv = '{3'b010, 8'd100, 7'd20, 1'b1, 1, 36, 1, 0};
    run_draw(hv, 2, "clr_mid");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
